// File: rtl/bit_packer_pkg.sv
// Shared types and constants for the bit_packer_arbiter block.
package bit_packer_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StStream,
        StDrain,
        StGap
    } state_e;

    // Widths for the default configuration (N_REQ=2, OWIDTH=32).
    localparam int unsigned ID_W   = $clog2(2);
    localparam int unsigned FILL_W = $clog2(32) + 1;

    // Outstanding packed words of the current frame; a handful at most.
    localparam int unsigned PEND_W = 4;

endpackage

// File: rtl/bit_packer_arbiter_rr_arbiter.sv
// Request arbiter: one-hot grant plus index. Round-robin after last_grant by default;
// defining BIT_PACKER_ARB_FIXED_PRIO_EN selects fixed lowest-index priority.
module rr_arbiter
    import bit_packer_pkg::*;
#(
    parameter int unsigned N_REQ = 2,
    parameter int unsigned IdW   = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] req,
    input  logic [IdW-1:0]   last_grant,
    output logic [N_REQ-1:0] grant,
    output logic [IdW-1:0]   grant_idx
);

    logic           found;
    logic [IdW-1:0] cand;

`ifdef BIT_PACKER_ARB_FIXED_PRIO_EN
    logic unused_last_grant;
    assign unused_last_grant = ^last_grant;

    always_comb begin
        found     = 1'b0;
        cand      = '0;
        grant_idx = '0;
        grant     = '0;
        for (int unsigned i = 0; i < N_REQ; i++) begin
            cand = IdW'(i);
            if (!found && req[cand]) begin
                found     = 1'b1;
                grant_idx = cand;
            end
        end
        grant[grant_idx] = found;
    end
`else
    always_comb begin
        found     = 1'b0;
        cand      = '0;
        grant_idx = '0;
        grant     = '0;
        // Search starts one past the previous winner, wrapping around.
        for (int unsigned k = 1; k <= N_REQ; k++) begin
            cand = IdW'((32'(last_grant) + k) % N_REQ);
            if (!found && req[cand]) begin
                found     = 1'b1;
                grant_idx = cand;
            end
        end
        grant[grant_idx] = found;
    end
`endif

endmodule

// File: rtl/bit_packer_arbiter.sv
// Shares one bit packer among N_REQ frame sources, one frame at a time, and tags packed
// output with source id and end-of-frame. Arbitration policy: BIT_PACKER_ARB_FIXED_PRIO_EN.
module bit_packer_arbiter
    import bit_packer_pkg::*;
#(
    parameter int unsigned N_REQ  = 2,
    parameter int unsigned IWIDTH = 8,
    parameter int unsigned OWIDTH = 32
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [N_REQ-1:0]         req,
    input  logic [N_REQ*IWIDTH-1:0]  req_data,
    input  logic [N_REQ-1:0]         req_last,
    output logic [N_REQ-1:0]         req_ready,
    output logic                     pk_en,
    output logic [IWIDTH-1:0]        pk_in,
    output logic                     pk_in_valid,
    input  logic [OWIDTH-1:0]        pk_out,
    input  logic                     pk_out_valid,
    output logic [OWIDTH-1:0]        out_data,
    output logic                     out_valid,
    output logic                     out_last,
    output logic [$clog2(N_REQ)-1:0] out_id,
    output logic                     busy
);

    localparam int unsigned IdW   = $clog2(N_REQ);
    localparam int unsigned FillW = $clog2(OWIDTH) + 1;

    state_e              state_q, state_d;
    logic                suppress_q, suppress_d;
    logic [IdW-1:0]      grant_q, grant_d;
    logic [IdW-1:0]      last_grant_q, last_grant_d;
    logic [FillW-1:0]    fill_q, fill_d;
    logic [PEND_W-1:0]   pend_q, pend_d;
    logic                pk_en_q, pk_en_d;
    logic [IWIDTH-1:0]   pk_in_q, pk_in_d;
    logic                pk_in_valid_q, pk_in_valid_d;
    logic [OWIDTH-1:0]   out_data_q, out_data_d;
    logic                out_valid_q, out_valid_d;
    logic                out_last_q, out_last_d;
    logic [IdW-1:0]      out_id_q, out_id_d;

    logic [N_REQ-1:0]    arb_grant;
    logic [IdW-1:0]      arb_idx;
    logic                accept;
    logic [IWIDTH-1:0]   word;
    logic [FillW:0]      fill_sum;
    logic                wrap;
    logic [FillW-1:0]    fill_nxt;
    logic [PEND_W-1:0]   pend_inc;
    logic                fwd;
    logic                pend_dec;
    logic                last_fwd;

    rr_arbiter #(
        .N_REQ (N_REQ),
        .IdW   (IdW)
    ) u_arb (
        .req        (req),
        .last_grant (last_grant_q),
        .grant      (arb_grant),
        .grant_idx  (arb_idx)
    );

    always_comb begin
        accept    = (state_q == StStream) && req[grant_q];
        req_ready = '0;
        req_ready[grant_q] = accept;
        word      = req_data[32'(grant_q) * IWIDTH +: IWIDTH];

        fill_sum  = {1'b0, fill_q} + (FillW + 1)'(IWIDTH);
        wrap      = fill_sum >= (FillW + 1)'(OWIDTH);
        fill_nxt  = wrap ? FillW'(fill_sum - (FillW + 1)'(OWIDTH)) : FillW'(fill_sum);
        // Every wrap yields a packed word; a non-empty remainder at frame end yields a flush word.
        pend_inc  = PEND_W'(wrap) + PEND_W'(req_last[grant_q] && (fill_nxt != '0));

        fwd       = pk_out_valid &&
                    ((state_q == StStream) || ((state_q == StDrain) && !suppress_q));
        pend_dec  = fwd && (pend_q != '0);
        last_fwd  = fwd && (state_q == StDrain) && (pend_q == PEND_W'(1));
    end

    always_comb begin
        state_d       = state_q;
        suppress_d    = suppress_q;
        grant_d       = grant_q;
        last_grant_d  = last_grant_q;
        fill_d        = fill_q;
        pend_d        = pend_q - PEND_W'(pend_dec);
        pk_en_d       = 1'b0;
        pk_in_d       = '0;
        pk_in_valid_d = 1'b0;
        out_valid_d   = fwd;
        out_last_d    = last_fwd;
        out_data_d    = fwd ? pk_out : out_data_q;
        out_id_d      = fwd ? grant_q : out_id_q;

        unique case (state_q)
            StIdle: begin
                if (|arb_grant) begin
                    grant_d = arb_idx;
                    state_d = StStream;
                end
            end
            StStream: begin
                if (accept) begin
                    pk_en_d       = 1'b1;
                    pk_in_d       = word;
                    pk_in_valid_d = 1'b1;
                    fill_d        = fill_nxt;
                    pend_d        = pend_q - PEND_W'(pend_dec) + pend_inc;
                    if (req_last[grant_q]) begin
                        state_d = StDrain;
                    end
                end
            end
            StDrain: begin
                // After reset the single pk_en=0 cycle has flushed the packer; skip forwarding.
                if (suppress_q || last_fwd) begin
                    state_d    = StGap;
                    suppress_d = 1'b0;
                    fill_d     = '0;
                    pend_d     = '0;
                end
            end
            StGap: begin
                last_grant_d = grant_q;
                state_d      = StIdle;
            end
            default: state_d = StDrain;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= StDrain;
            suppress_q    <= 1'b1;
            grant_q       <= IdW'(N_REQ - 1);
            last_grant_q  <= IdW'(N_REQ - 1);
            fill_q        <= '0;
            pend_q        <= '0;
            pk_en_q       <= 1'b0;
            pk_in_q       <= '0;
            pk_in_valid_q <= 1'b0;
            out_data_q    <= '0;
            out_valid_q   <= 1'b0;
            out_last_q    <= 1'b0;
            out_id_q      <= '0;
        end else begin
            state_q       <= state_d;
            suppress_q    <= suppress_d;
            grant_q       <= grant_d;
            last_grant_q  <= last_grant_d;
            fill_q        <= fill_d;
            pend_q        <= pend_d;
            pk_en_q       <= pk_en_d;
            pk_in_q       <= pk_in_d;
            pk_in_valid_q <= pk_in_valid_d;
            out_data_q    <= out_data_d;
            out_valid_q   <= out_valid_d;
            out_last_q    <= out_last_d;
            out_id_q      <= out_id_d;
        end
    end

    assign pk_en       = pk_en_q;
    assign pk_in       = pk_in_q;
    assign pk_in_valid = pk_in_valid_q;
    assign out_data    = out_data_q;
    assign out_valid   = out_valid_q;
    assign out_last    = out_last_q;
    assign out_id      = out_id_q;
    assign busy        = state_q != StIdle;

endmodule

// File: tb/tb_bit_packer_arbiter.sv
// Directed bench for bit_packer_arbiter with FWFT source models and a behavioural packer.
module tb_bit_packer_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [1:0]  req;
    logic [15:0] req_data;
    logic [1:0]  req_last;
    logic [1:0]  req_ready;
    logic        pk_en;
    logic [7:0]  pk_in;
    logic        pk_in_valid;
    logic [31:0] pk_out = '0;
    logic        pk_out_valid = 1'b0;
    logic [31:0] out_data;
    logic        out_valid;
    logic        out_last;
    logic [0:0]  out_id;
    logic        busy;

    always #5 clk = ~clk;

    bit_packer_arbiter #(
        .N_REQ  (2),
        .IWIDTH (8),
        .OWIDTH (32)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .req          (req),
        .req_data     (req_data),
        .req_last     (req_last),
        .req_ready    (req_ready),
        .pk_en        (pk_en),
        .pk_in        (pk_in),
        .pk_in_valid  (pk_in_valid),
        .pk_out       (pk_out),
        .pk_out_valid (pk_out_valid),
        .out_data     (out_data),
        .out_valid    (out_valid),
        .out_last     (out_last),
        .out_id       (out_id),
        .busy         (busy)
    );

    // Source FIFOs: {last, byte} entries, popped on req_ready.
    logic [8:0] smem [2][64];
    int         wp [2] = '{0, 0};
    int         rp [2] = '{0, 0};
    logic       src_clr = 1'b0;

    for (genvar gi = 0; gi < 2; gi++) begin : g_src
        assign req[gi]              = rp[gi] != wp[gi];
        assign req_data[gi*8 +: 8]  = smem[gi][rp[gi] % 64][7:0];
        assign req_last[gi]         = smem[gi][rp[gi] % 64][8];
    end

    always @(posedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (src_clr) rp[i] <= wp[i];
            else if (req_ready[i]) rp[i] <= rp[i] + 1;
        end
    end

    // Packer: MSB-first packing, partial word flushed right-aligned when pk_en drops. No reset.
    logic [31:0] acc = '0;
    int          pfill = 0;
    always @(posedge clk) begin
        pk_out_valid <= 1'b0;
        if (pk_en && pk_in_valid) begin
            if (pfill + 8 == 32) begin
                pk_out       <= {acc[23:0], pk_in};
                pk_out_valid <= 1'b1;
                acc          <= '0;
                pfill        <= 0;
            end else begin
                acc   <= {acc[23:0], pk_in};
                pfill <= pfill + 8;
            end
        end else if (!pk_en && pfill != 0) begin
            pk_out       <= acc;
            pk_out_valid <= 1'b1;
            acc          <= '0;
            pfill        <= 0;
        end
    end

    // Output and req_ready recorders.
    int          cyc = 0;
    logic [31:0] od [64];
    logic        ol [64];
    logic [0:0]  oi [64];
    int          oc [64];
    int          n_out = 0;
    int          rc [64];
    int          n_rdy = 0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (out_valid) begin
            od[n_out] <= out_data;
            ol[n_out] <= out_last;
            oi[n_out] <= out_id;
            oc[n_out] <= cyc;
            n_out     <= n_out + 1;
        end
        if (req_ready != 2'b00) begin
            rc[n_rdy] <= cyc;
            n_rdy     <= n_rdy + 1;
        end
    end

    int checks = 0;
    int fails  = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(negedge clk);
            #1;
        end
    endtask

    task automatic push(input int s, input logic [7:0] b, input logic l);
        smem[s][wp[s] % 64] = {l, b};
        wp[s] = wp[s] + 1;
    endtask

    task automatic wait_outs(input string tag, input int target, input int budget);
        int k = 0;
        while (n_out < target && k < budget) begin
            step(1);
            k++;
        end
        chk(tag, 32'(n_out >= target), 32'd1);
    endtask

    logic [7:0] exp_d [6];
    logic [0:0] exp_i [6];
    int base;
    int k;
    int n_before;
    int r0;

    initial begin
        // Reset values while rst is held.
        step(3);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_data", out_data, 32'd0);
        chk("rst_out_last", 32'(out_last), 32'd0);
        chk("rst_out_id", 32'(out_id), 32'd0);
        chk("rst_pk_en", 32'(pk_en), 32'd0);
        chk("rst_pk_in_valid", 32'(pk_in_valid), 32'd0);
        chk("rst_req_ready", 32'(req_ready), 32'd0);
        rst = 1'b0;

        // 1: four-byte frame packs into exactly one word.
        push(0, 8'hAA, 1'b0);
        push(0, 8'hBB, 1'b0);
        push(0, 8'hCC, 1'b0);
        push(0, 8'hDD, 1'b1);
        wait_outs("t1_wait", 1, 60);
        chk("t1_data", od[0], 32'hAABBCCDD);
        chk("t1_last", 32'(ol[0]), 32'd1);
        chk("t1_id", 32'(oi[0]), 32'd0);
        step(10);
        chk("t1_no_flush_word", 32'(n_out), 32'd1);
        chk("t1_ready_pulses", 32'(n_rdy), 32'd4);
        // 6: three cycles from last accept to out_valid.
        chk("t6_latency", 32'(oc[0] - rc[3]), 32'd3);

        // 2: five-byte frame from source 1: one full word then a flushed partial word.
        for (int i = 1; i <= 5; i++) push(1, 8'(i), i == 5);
        wait_outs("t2_wait", 3, 60);
        chk("t2_w0_data", od[1], 32'h01020304);
        chk("t2_w0_last", 32'(ol[1]), 32'd0);
        chk("t2_w0_id", 32'(oi[1]), 32'd1);
        chk("t2_w1_data", od[2], 32'h00000005);
        chk("t2_w1_last", 32'(ol[2]), 32'd1);
        chk("t2_w1_id", 32'(oi[2]), 32'd1);
        step(6);
        chk("t2_idle", 32'(busy), 32'd0);

        // 3: both sources hold three one-byte frames.
        for (int i = 0; i < 3; i++) begin
            push(0, 8'hA0 + 8'(i), 1'b1);
            push(1, 8'hB0 + 8'(i), 1'b1);
        end
`ifdef BIT_PACKER_ARB_FIXED_PRIO_EN
        exp_d = '{8'hA0, 8'hA1, 8'hA2, 8'hB0, 8'hB1, 8'hB2};
        exp_i = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
`else
        exp_d = '{8'hA0, 8'hB0, 8'hA1, 8'hB1, 8'hA2, 8'hB2};
        exp_i = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
`endif
        wait_outs("t3_wait", 9, 200);
        for (int j = 0; j < 6; j++) begin
            chk($sformatf("t3_id%0d", j), 32'(oi[3 + j]), 32'(exp_i[j]));
            chk($sformatf("t3_data%0d", j), od[3 + j], {24'h0, exp_d[j]});
            chk($sformatf("t3_last%0d", j), 32'(ol[3 + j]), 32'd1);
        end
        step(6);

        // 4: reset after two accepted bytes; stale bits must never surface.
        base = rp[0];
        push(0, 8'h11, 1'b0);
        push(0, 8'h22, 1'b0);
        push(0, 8'h33, 1'b0);
        push(0, 8'h44, 1'b1);
        k = 0;
        while (rp[0] != base + 2 && k < 40) begin
            step(1);
            k++;
        end
        chk("t4_two_accepted", 32'(rp[0] - base), 32'd2);
        rst     = 1'b1;
        src_clr = 1'b1;
        n_before = n_out;
        step(1);
        rst     = 1'b0;
        src_clr = 1'b0;
        step(20);
        chk("t4_no_out_after_rst", 32'(n_out), 32'(n_before));
        push(0, 8'h55, 1'b0);
        push(0, 8'h66, 1'b0);
        push(0, 8'h77, 1'b0);
        push(0, 8'h88, 1'b1);
        wait_outs("t4_wait", n_before + 1, 60);
        chk("t4_data", od[n_before], 32'h55667788);
        chk("t4_last", 32'(ol[n_before]), 32'd1);
        chk("t4_id", 32'(oi[n_before]), 32'd0);
        step(10);
        chk("t4_single_word", 32'(n_out), 32'(n_before + 1));

        // 5: back-to-back one-byte frames from source 0.
        n_before = n_out;
        r0 = n_rdy;
        push(0, 8'hC1, 1'b1);
        push(0, 8'hC2, 1'b1);
        wait_outs("t5_wait", n_before + 2, 80);
        chk("t5_w0_data", od[n_before], 32'h000000C1);
        chk("t5_w0_last", 32'(ol[n_before]), 32'd1);
        chk("t5_w1_data", od[n_before + 1], 32'h000000C2);
        chk("t5_w1_last", 32'(ol[n_before + 1]), 32'd1);
        chk("t5_ready_spacing", 32'(rc[r0 + 1] - rc[r0]), 32'd6);

        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end

endmodule
